adder_subtractor_16bit_overflow: RTL and testbench

16-bit two's-complement adder/subtractor with registered result and a full status-flag set: carry, signed overflow, unsigned overflow, zero and negative. It is the arithmetic core of the ALU datapath. Downstream condition-code logic reads its flags directly. Operands and the operation select are sampled every clock, and results appear one cycle later.

---
 rtl/adder_subtractor_16bit_overflow_if.sv | 26 ++
 rtl/adder_subtractor_16bit_overflow.sv | 57 +++++
 tb/tb_adder_subtractor_16bit_overflow.sv | 116 +++++++++++
 3 files changed

// File: rtl/adder_subtractor_16bit_overflow_if.sv
// Operand and result bundle for the 16-bit adder/subtractor.
// The master drives the operands and the operation select.
// The slave returns the registered result together with its status flags.
interface adder_subtractor_16bit_overflow_if;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] result;
    logic        carry_out;
    logic        signed_overflow;
    logic        unsigned_overflow;
    logic        zero_flag;
    logic        negative_flag;

    modport master (
        output a, b, sub,
        input  result, carry_out, signed_overflow, unsigned_overflow,
               zero_flag, negative_flag
    );

    modport slave (
        input  a, b, sub,
        output result, carry_out, signed_overflow, unsigned_overflow,
               zero_flag, negative_flag
    );
endinterface

// File: rtl/adder_subtractor_16bit_overflow.sv
// 16-bit two's-complement adder/subtractor with a registered result and flags.
// A ripple-carry chain of full-adder cells exposes both c15 and c16.
// The signed and unsigned overflow flags are derived from those two carries.
// The result and all five flags are captured together in one register bank,
// so no flag can ever be skewed from the result it describes.
module adder_subtractor_16bit_overflow (
    input  logic                               clk,
    input  logic                               rst,
    adder_subtractor_16bit_overflow_if.slave   bus
);

    logic [15:0] b_eff;
    logic [16:0] carry;
    logic [15:0] sum;
    logic        so_next;
    logic        uo_next;
    logic        zero_next;

    // Ripple-carry core: subtraction is A + ~B + 1, with carry-in = sub.
    // NOTE: every signal driven here gets a value on every pass, so no latch is inferred.
    always_comb begin
        b_eff    = bus.b ^ {16{bus.sub}};
        carry    = '0;
        sum      = '0;
        carry[0] = bus.sub;
        for (int i = 0; i < 16; i++) begin
            sum[i]     = bus.a[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (bus.a[i] & b_eff[i]) | (carry[i] & (bus.a[i] ^ b_eff[i]));
        end
        // Signed overflow is the carry into the sign bit disagreeing with the carry out of it.
        so_next   = carry[15] ^ carry[16];
        // In subtract mode a missing carry out is a borrow.
        uo_next   = carry[16] ^ bus.sub;
        zero_next = (sum == 16'h0000);
    end

    // Output register bank: reset wins over the operation sampled on the same edge.
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result            <= '0;
            bus.carry_out         <= 1'b0;
            bus.signed_overflow   <= 1'b0;
            bus.unsigned_overflow <= 1'b0;
            bus.zero_flag         <= 1'b0;
            bus.negative_flag     <= 1'b0;
        end else begin
            bus.result            <= sum;
            bus.carry_out         <= carry[16];
            bus.signed_overflow   <= so_next;
            bus.unsigned_overflow <= uo_next;
            bus.zero_flag         <= zero_next;
            bus.negative_flag     <= sum[15];
        end
    end

endmodule

// File: tb/tb_adder_subtractor_16bit_overflow.sv
// Scoreboard testbench for adder_subtractor_16bit_overflow.
// The driver applies one directed vector per clock and queues its hand-computed response.
// The monitor pops one expected response after each rising edge and compares it with the outputs.
module tb_adder_subtractor_16bit_overflow;

    typedef struct packed {
        logic [15:0] result;
        logic        c;
        logic        so;
        logic        uo;
        logic        z;
        logic        n;
    } resp_t;

    typedef struct {
        string name;
        resp_t exp;
    } entry_t;

    logic clk;
    logic rst;
    int   applied;
    int   miscompares;
    entry_t sb[$];

    adder_subtractor_16bit_overflow_if bus ();

    adder_subtractor_16bit_overflow dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation, queue its expected response, then wait for that edge to pass.
    task automatic apply(input string name, input logic r, input logic [15:0] a,
                         input logic [15:0] b, input logic s, input logic [15:0] res,
                         input logic c, input logic so, input logic uo,
                         input logic z, input logic n);
        entry_t e;
        rst     = r;
        bus.a   = a;
        bus.b   = b;
        bus.sub = s;
        e.name  = name;
        e.exp   = '{result: res, c: c, so: so, uo: uo, z: z, n: n};
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: outputs change only on the rising edge, so sample just after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                entry_t e;
                resp_t  act;
                e   = sb.pop_front();
                act = '{result: bus.result, c: bus.carry_out, so: bus.signed_overflow,
                        uo: bus.unsigned_overflow, z: bus.zero_flag, n: bus.negative_flag};
                applied++;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got result=%h C=%b SO=%b UO=%b Z=%b N=%b, want result=%h C=%b SO=%b UO=%b Z=%b N=%b",
                             e.name, act.result, act.c, act.so, act.uo, act.z, act.n,
                             e.exp.result, e.exp.c, e.exp.so, e.exp.uo, e.exp.z, e.exp.n);
                end
            end
        end
    end

    initial begin
        applied     = 0;
        miscompares = 0;
        //     name            rst a        b        sub result   C    SO   UO   Z    N
        apply("reset0",       1, 16'h1234, 16'h0001, 0, 16'h0000, 0, 0, 0, 0, 0);
        apply("reset1",       1, 16'hFFFF, 16'h0001, 0, 16'h0000, 0, 0, 0, 0, 0);
        apply("100+200",      0, 16'd100,  16'd200,  0, 16'd300,  0, 0, 0, 0, 0);
        apply("100-100",      0, 16'd100,  16'd100,  1, 16'h0000, 1, 0, 0, 1, 0);
        apply("0-1",          0, 16'h0000, 16'h0001, 1, 16'hFFFF, 0, 0, 1, 0, 1);
        apply("FFFF+1",       0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 1, 1, 0);
        apply("8000+8000",    0, 16'h8000, 16'h8000, 0, 16'h0000, 1, 1, 1, 1, 0);
        apply("7FFF+1",       0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 0, 0, 1);
        apply("8000+FFFF",    0, 16'h8000, 16'hFFFF, 0, 16'h7FFF, 1, 1, 1, 0, 0);
        apply("7FFF-FFFF",    0, 16'h7FFF, 16'hFFFF, 1, 16'h8000, 0, 1, 1, 0, 1);
        apply("8000-1",       0, 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1, 0, 0, 0);
        apply("E000+E000",    0, 16'hE000, 16'hE000, 0, 16'hC000, 1, 0, 1, 0, 1);
        apply("F000+100",     0, 16'hF000, 16'd100,  0, 16'hF064, 0, 0, 0, 0, 1);
        // Back-to-back operands, changing every cycle.
        apply("1234+1111",    0, 16'h1234, 16'h1111, 0, 16'h2345, 0, 0, 0, 0, 0);
        apply("5-3",          0, 16'h0005, 16'h0003, 1, 16'h0002, 1, 0, 0, 0, 0);
        apply("3-5",          0, 16'h0003, 16'h0005, 1, 16'hFFFE, 0, 0, 1, 0, 1);
        apply("A5A5+5A5A",    0, 16'hA5A5, 16'h5A5A, 0, 16'hFFFF, 0, 0, 0, 0, 1);
        // Mid-stream reset alongside 1+1: the sum 2 must never appear.
        apply("rst_1+1",      1, 16'h0001, 16'h0001, 0, 16'h0000, 0, 0, 0, 0, 0);
        apply("10-1",         0, 16'h0010, 16'h0001, 1, 16'h000F, 1, 0, 0, 0, 0);
        apply("4000+4000",    0, 16'h4000, 16'h4000, 0, 16'h8000, 0, 1, 0, 0, 1);
        apply("0-0",          0, 16'h0000, 16'h0000, 1, 16'h0000, 1, 0, 0, 1, 0);
        apply("7FFF+8000",    0, 16'h7FFF, 16'h8000, 0, 16'hFFFF, 0, 0, 0, 0, 1);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d responses still pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
